// File: rtl/ula_74181_if.sv
// Operand/result bundle for the ula_74181_sync ALU slice.
// When ULA_PG_OUT_EN is defined, the bundle also carries the p_n/g_n lookahead outputs.
interface ula_74181_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       m;
    logic       c_in;
    logic [3:0] f;
    logic       c_out;
    logic       a_eq_b;
`ifdef ULA_PG_OUT_EN
    logic       p_n;
    logic       g_n;

    modport master (output a, b, s, m, c_in, input f, c_out, a_eq_b, p_n, g_n);
    modport slave  (input a, b, s, m, c_in, output f, c_out, a_eq_b, p_n, g_n);
`else
    modport master (output a, b, s, m, c_in, input f, c_out, a_eq_b);
    modport slave  (input a, b, s, m, c_in, output f, c_out, a_eq_b);
`endif
endinterface

// File: rtl/ula_74181_sync.sv
// 74181-equivalent 4-bit ALU slice, active-high data, active-low carries, one cycle of latency.
// Defining ULA_PG_OUT_EN adds registered active-low group propagate/generate outputs (p_n, g_n).
module ula_74181_sync (
    input  logic        clk,
    input  logic        rst,
    ula_74181_if.slave  bus
);

    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;
    logic [3:0] f_next;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        x      = '0;
        y      = '0;
        sum    = '0;
        f_next = '0;
        for (int i = 0; i < 4; i++) begin
            x[i] = bus.a[i] | (bus.b[i] & bus.s[0]) | (~bus.b[i] & bus.s[1]);
            y[i] = (bus.a[i] & ~bus.b[i] & bus.s[2]) | (bus.a[i] & bus.b[i] & bus.s[3]);
        end
        // The carry chain runs in both modes; logic mode only ignores it for f.
        sum    = {1'b0, x} + {1'b0, y} + {4'b0000, ~bus.c_in};
        f_next = bus.m ? ~(x ^ y) : sum[3:0];
    end

`ifdef ULA_PG_OUT_EN
    logic [3:0] p;
    logic [3:0] g;
    logic       grp_p;
    logic       grp_g;

    always_comb begin
        p     = x & ~y;
        g     = y;
        grp_p = &p;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.f      <= 4'b0000;
            bus.c_out  <= 1'b1;
            bus.a_eq_b <= 1'b0;
`ifdef ULA_PG_OUT_EN
            bus.p_n    <= 1'b1;
            bus.g_n    <= 1'b1;
`endif
        end else begin
            bus.f      <= f_next;
            bus.c_out  <= ~sum[4];
            bus.a_eq_b <= &f_next;
`ifdef ULA_PG_OUT_EN
            bus.p_n    <= ~grp_p;
            bus.g_n    <= ~grp_g;
`endif
        end
    end

endmodule

// File: tb/tb_ula_74181_sync.sv
// Self-checking bench for ula_74181_sync: directed cases, exhaustive sweep and random traffic
// against a function-table reference model (p_n/g_n also checked when ULA_PG_OUT_EN is defined).
module tb_ula_74181_sync;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    ula_74181_if bus ();

    ula_74181_sync dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ULA_PG_OUT_EN
    localparam int OW = 8;
`else
    localparam int OW = 6;
`endif

    typedef struct packed {
        logic [3:0] f;
        logic       c_out;
        logic       a_eq_b;
        logic       p_n;
        logic       g_n;
    } exp_t;

    // Arithmetic function table with no carry in, as plain 5-bit-or-wider integer sums.
    // "-1" terms are written as +15 and "-B-1" as +(15-B), i.e. modulo-16 two's complement.
    function automatic int arith_base(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
        int ia;
        int ib;
        int nb;
        ia = int'(a);
        ib = int'(b);
        nb = 15 - ib;
        case (s)
            4'd0:    return ia;
            4'd1:    return ia | ib;
            4'd2:    return ia | nb;
            4'd3:    return 15;
            4'd4:    return ia + (ia & nb);
            4'd5:    return (ia | ib) + (ia & nb);
            4'd6:    return ia + nb;
            4'd7:    return (ia & nb) + 15;
            4'd8:    return ia + (ia & ib);
            4'd9:    return ia + ib;
            4'd10:   return (ia | nb) + (ia & ib);
            4'd11:   return (ia & ib) + 15;
            4'd12:   return ia + ia;
            4'd13:   return (ia | ib) + ia;
            4'd14:   return (ia | nb) + ia;
            default: return ia + 15;
        endcase
    endfunction

    function automatic logic [3:0] logic_fn(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
        case (s)
            4'd0:    return ~a;
            4'd1:    return ~(a | b);
            4'd2:    return ~a & b;
            4'd3:    return 4'b0000;
            4'd4:    return ~(a & b);
            4'd5:    return ~b;
            4'd6:    return a ^ b;
            4'd7:    return a & ~b;
            4'd8:    return ~a | b;
            4'd9:    return ~(a ^ b);
            4'd10:   return b;
            4'd11:   return a & b;
            4'd12:   return 4'b1111;
            4'd13:   return a | ~b;
            4'd14:   return a | b;
            default: return a;
        endcase
    endfunction

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                                   input logic m, input logic c_in);
        exp_t e;
        int   t;
        int   total;
        t        = arith_base(a, b, s);
        total    = t + (c_in ? 0 : 1);
        e.f      = m ? logic_fn(a, b, s) : 4'(total);
        e.c_out  = (total < 16);
        e.a_eq_b = (e.f == 4'b1111);
        // The group propagates when the carry-free sum is exactly 15 and generates when it overflows.
        e.p_n    = (t != 15);
        e.g_n    = (t < 16);
        return e;
    endfunction

    function automatic logic [OW-1:0] pack(input exp_t e);
`ifdef ULA_PG_OUT_EN
        return {e.f, e.c_out, e.a_eq_b, e.p_n, e.g_n};
`else
        return {e.f, e.c_out, e.a_eq_b};
`endif
    endfunction

    function automatic logic [OW-1:0] observed();
`ifdef ULA_PG_OUT_EN
        return {bus.f, bus.c_out, bus.a_eq_b, bus.p_n, bus.g_n};
`else
        return {bus.f, bus.c_out, bus.a_eq_b};
`endif
    endfunction

    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                        input logic m, input logic c_in);
        bus.a    = a;
        bus.b    = b;
        bus.s    = s;
        bus.m    = m;
        bus.c_in = c_in;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t          want;
        logic [OW-1:0] got;
        rst = 1'b1;
        step(4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b1);
        want = '{f: 4'b0000, c_out: 1'b1, a_eq_b: 1'b0, p_n: 1'b1, g_n: 1'b1};
        got  = observed();
        tests_run++;
        if (got !== pack(want)) begin
            tests_failed++;
            $display("FAIL reset_state: got %b want %b", got, pack(want));
        end
        rst = 1'b0;
        step(4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b1);
        tests_run++;
        if ({bus.f, bus.a_eq_b} !== {4'b1111, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_release: got f=%b a_eq_b=%b want f=1111 a_eq_b=1", bus.f, bus.a_eq_b);
        end
    endtask

    task automatic test_reset_override();
        exp_t          want;
        logic [OW-1:0] got;
        step(4'b0101, 4'b1010, 4'b1001, 1'b0, 1'b1);
        rst = 1'b1;
        step(4'b0101, 4'b1010, 4'b1001, 1'b0, 1'b0);
        want = '{f: 4'b0000, c_out: 1'b1, a_eq_b: 1'b0, p_n: 1'b1, g_n: 1'b1};
        got  = observed();
        tests_run++;
        if (got !== pack(want)) begin
            tests_failed++;
            $display("FAIL reset_override: got %b want %b", got, pack(want));
        end
        rst = 1'b0;
    endtask

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic       m;
        logic       c_in;
        logic [3:0] f;
        logic       chk_c;
        logic       c_out;
    } dir_t;

    task automatic test_directed();
        dir_t cases[7];
        cases[0] = '{"add_a_plus_b",  4'b0101, 4'b1010, 4'b1001, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b1};
        cases[1] = '{"sub_a_minus_b", 4'b0101, 4'b0011, 4'b0110, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0};
        cases[2] = '{"wrap_a_plus_1", 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0};
        cases[3] = '{"a_minus_1",     4'b1001, 4'b0110, 4'b1111, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0};
        cases[4] = '{"logic_xor",     4'b1011, 4'b1101, 4'b0110, 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0};
        cases[5] = '{"logic_and",     4'b1010, 4'b1011, 4'b1011, 1'b1, 1'b0, 4'b1010, 1'b0, 1'b0};
        cases[6] = '{"logic_zero",    4'b0110, 4'b1001, 4'b0011, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0};
        foreach (cases[i]) begin
            step(cases[i].a, cases[i].b, cases[i].s, cases[i].m, cases[i].c_in);
            tests_run++;
            if (bus.f !== cases[i].f || bus.a_eq_b !== (cases[i].f == 4'b1111)
                || (cases[i].chk_c && bus.c_out !== cases[i].c_out)) begin
                tests_failed++;
                $display("FAIL %s: got f=%b c_out=%b a_eq_b=%b want f=%b c_out=%b a_eq_b=%b",
                         cases[i].name, bus.f, bus.c_out, bus.a_eq_b, cases[i].f,
                         cases[i].chk_c ? cases[i].c_out : bus.c_out, (cases[i].f == 4'b1111));
            end
        end
    endtask

    task automatic test_sweep();
        logic [13:0]   v;
        logic [OW-1:0] want;
        logic [OW-1:0] got;
        for (int i = 0; i < 16384; i++) begin
            v    = 14'(i);
            step(v[3:0], v[7:4], v[11:8], v[12], v[13]);
            want = pack(model(v[3:0], v[7:4], v[11:8], v[12], v[13]));
            got  = observed();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL sweep a=%b b=%b s=%b m=%b c_in=%b: got %b want %b",
                         v[3:0], v[7:4], v[11:8], v[12], v[13], got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0]   v;
        logic [OW-1:0] want;
        logic [OW-1:0] got;
        for (int i = 0; i < 1000; i++) begin
            v    = 14'($urandom);
            step(v[3:0], v[7:4], v[11:8], v[12], v[13]);
            want = pack(model(v[3:0], v[7:4], v[11:8], v[12], v[13]));
            got  = observed();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL random a=%b b=%b s=%b m=%b c_in=%b: got %b want %b",
                         v[3:0], v[7:4], v[11:8], v[12], v[13], got, want);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bus.a        = '0;
        bus.b        = '0;
        bus.s        = '0;
        bus.m        = 1'b0;
        bus.c_in     = 1'b1;
        test_reset();
        test_directed();
        test_reset_override();
        test_sweep();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
